// File: rtl/winograd_pkg.sv
// Shared types and constants for the dual-mode Winograd output transform.
// Modes, FSM states, per-mode loop bounds and the A^T power-of-two coefficients.
package winograd_pkg;

    typedef enum logic {
        WG_F43 = 1'b0,
        WG_F23 = 1'b1
    } wg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_OUT   = 2'd3
    } wg_state_e;

    // Non-unit A^T magnitudes are 2, 4 and 8, realised as left shifts.
    localparam int AT_SHL_X2 = 1;
    localparam int AT_SHL_X4 = 2;
    localparam int AT_SHL_X8 = 3;

    // Last column index of PASS1 (N_IN-1) and last row index of PASS2 (N_OUT-1).
    function automatic logic [2:0] last_in_idx(input wg_mode_e m);
        return (m == WG_F43) ? 3'd5 : 3'd3;
    endfunction

    function automatic logic [2:0] last_out_idx(input wg_mode_e m);
        return (m == WG_F43) ? 3'd3 : 3'd1;
    endfunction

endpackage

// File: rtl/winograd_post_transform_1d_dual.sv
// Combinational 1D A^T transform, 6 in / 4 out (F43) or 4 in / 2 out (F23), shift/add only.
// Outputs not produced by the selected mode are driven to exact zero.
module winograd_post_transform_1d_dual
    import winograd_pkg::*;
#(
    parameter int W = 74
) (
    input  wg_mode_e             mode,
    input  logic [0:5][W-1:0]    d,
    output logic [0:3][W-1:0]    y
);

    logic signed [W-1:0] d0, d1, d2, d3, d4, d5;
    logic signed [W-1:0] s12, m12, s34, m34;

    assign d0 = $signed(d[0]);
    assign d1 = $signed(d[1]);
    assign d2 = $signed(d[2]);
    assign d3 = $signed(d[3]);
    assign d4 = $signed(d[4]);
    assign d5 = $signed(d[5]);

    always_comb begin
        s12 = d1 + d2;
        m12 = d1 - d2;
        s34 = d3 + d4;
        m34 = d3 - d4;
        y   = '0;
        if (mode == WG_F43) begin
            y[0] = d0 + s12 + s34;
            y[1] = m12 + (m34 <<< AT_SHL_X2);
            y[2] = s12 + (s34 <<< AT_SHL_X4);
            y[3] = m12 + (m34 <<< AT_SHL_X8) + d5;
        end else begin
            y[0] = d0 + s12;
            y[1] = m12 - d3;
        end
    end

endmodule

// File: rtl/winograd_output_transform.sv
// Y = A^T*M*A per tile (F43 or F23) with rounding shift and saturation; valid after N_IN+N_OUT edges.
// Tile held while out_ready is low; no new tile accepted until the output handshake completes.
module winograd_output_transform
    import winograd_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 64,
    parameter int SHIFT  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_mode,
    input  logic signed [0:5][0:5][DATA_W-1:0] in_tile,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_mode,
    output logic signed [0:3][0:3][OUT_W-1:0] out_tile,
    output logic                              out_sat
);

    localparam int INT_W = DATA_W + 10;
    localparam logic signed [INT_W-1:0] RND     = (INT_W'(1) << SHIFT) >> 1;
    localparam logic signed [INT_W-1:0] SAT_MAX = {{(INT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] SAT_MIN = ~SAT_MAX;

    wg_state_e                      state, state_nxt;
    logic [2:0]                     idx;
    wg_mode_e                       mode_q;
    logic [0:5][0:5][DATA_W-1:0]    cap;
    logic [0:3][0:5][INT_W-1:0]     temp;
    logic [0:5][INT_W-1:0]          tf_in;
    logic [0:3][INT_W-1:0]          tf_out;
    logic signed [INT_W-1:0]        rnd_val [4];
    logic signed [INT_W-1:0]        shr_val [4];
    logic [0:3][OUT_W-1:0]          res;
    logic [0:3]                     clip;
    logic                           pass1_last, pass2_last;

    assign pass1_last = (idx == last_in_idx(mode_q));
    assign pass2_last = (idx == last_out_idx(mode_q));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == ST_IDLE);
        case (state)
            ST_IDLE:  if (in_valid)   state_nxt = ST_PASS1;
            ST_PASS1: if (pass1_last) state_nxt = ST_PASS2;
            ST_PASS2: if (pass2_last) state_nxt = ST_OUT;
            ST_OUT:   if (out_ready)  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // One shared 1D transform: capture columns in PASS1, temp rows in PASS2.
    always_comb begin
        tf_in = '0;
        for (int r = 0; r < 6; r++) begin
            if (state == ST_PASS2)
                tf_in[r] = temp[idx[1:0]][r];
            else
                tf_in[r] = {{(INT_W-DATA_W){cap[r][idx][DATA_W-1]}}, cap[r][idx]};
        end
    end

    winograd_post_transform_1d_dual #(.W(INT_W)) u_tf (
        .mode (mode_q),
        .d    (tf_in),
        .y    (tf_out)
    );

    // Round-half-up, arithmetic shift, clip to the signed output range.
    always_comb begin
        clip = '0;
        res  = '0;
        for (int c = 0; c < 4; c++) begin
            rnd_val[c] = $signed(tf_out[c]) + RND;
            shr_val[c] = rnd_val[c] >>> SHIFT;
            if (shr_val[c] > SAT_MAX) begin
                res[c]  = SAT_MAX[OUT_W-1:0];
                clip[c] = 1'b1;
            end else if (shr_val[c] < SAT_MIN) begin
                res[c]  = SAT_MIN[OUT_W-1:0];
                clip[c] = 1'b1;
            end else begin
                res[c]  = shr_val[c][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            cap    <= in_tile;
            mode_q <= wg_mode_e'(in_mode);
        end
        if (state == ST_PASS1) begin
            for (int k = 0; k < 4; k++) temp[k][idx] <= tf_out[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_mode  <= 1'b0;
            out_tile  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    idx      <= '0;
                    out_sat  <= 1'b0;
                    out_tile <= '0;
                end
                ST_PASS1: idx <= pass1_last ? 3'd0 : idx + 3'd1;
                ST_PASS2: begin
                    // Unused F23 columns are zero out of the transform, so they round to zero.
                    for (int c = 0; c < 4; c++) out_tile[idx[1:0]][c] <= res[c];
                    out_sat <= out_sat | (|clip);
                    if (pass2_last) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_mode  <= mode_q;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
